// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write-port arbiter:
// FSM state encodings and a constant-evaluable ceil(log2) helper.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BURST   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // Index width for a vector of 'value' entries; never narrower than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin select: first set request searching upward from
// ptr+1, wrapping modulo P_REQ_NUM. Returns a one-hot grant and its index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int P_REQ_NUM   = 4,
  parameter int P_IDX_WIDTH = clog2(P_REQ_NUM)
) (
  input  logic [P_REQ_NUM-1:0]   req,
  input  logic [P_IDX_WIDTH-1:0] ptr,
  output logic [P_REQ_NUM-1:0]   grant,
  output logic [P_IDX_WIDTH-1:0] idx
);

  // Priority search starting just after the last served requester
  always_comb begin
    int                   cand_int;
    logic [P_IDX_WIDTH-1:0] cand;
    logic                 found;
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand_int = 0;
    cand     = '0;
    for (int off = 1; off <= P_REQ_NUM; off++) begin
      cand_int = (int'(ptr) + off) % P_REQ_NUM;
      cand     = P_IDX_WIDTH'(cand_int);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port between P_REQ_NUM burst requesters, round-robin.
// The owner keeps the port until its burst completes or it drops its request.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int P_REQ_NUM    = 4,
  parameter int P_DATA_WIDTH = 4,
  parameter int P_LEN_WIDTH  = 5
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [P_REQ_NUM-1:0]              i_req,
  input  logic [P_REQ_NUM*P_LEN_WIDTH-1:0]  i_len,
  input  logic [P_REQ_NUM*P_DATA_WIDTH-1:0] i_wdata,
  output logic [P_REQ_NUM-1:0]              o_grant,
  output logic [P_REQ_NUM-1:0]              o_ack,
  output logic [clog2(P_REQ_NUM)-1:0]       o_owner,
  output logic                              o_busy,
  output logic                              o_fifo_wr_en,
  output logic [P_DATA_WIDTH-1:0]           o_fifo_wdata,
  input  logic                              i_fifo_full
);

  localparam int IW = clog2(P_REQ_NUM);
  localparam logic [P_LEN_WIDTH-1:0] LEN_ONE = P_LEN_WIDTH'(1'b1);

  arb_state_t               state_r;
  arb_state_t               state_s;
  logic [P_REQ_NUM-1:0]     grant_r;
  logic [IW-1:0]            owner_r;
  logic [IW-1:0]            ptr_r;
  logic [P_LEN_WIDTH-1:0]   count_r;
  logic                     busy_r;

  logic [P_REQ_NUM-1:0]     pick_grant_s;
  logic [IW-1:0]            pick_idx_s;
  logic [P_LEN_WIDTH-1:0]   len_arr_s  [P_REQ_NUM];
  logic [P_DATA_WIDTH-1:0]  data_arr_s [P_REQ_NUM];
  logic [P_LEN_WIDTH-1:0]   win_len_s;
  logic                     own_req_s;
  logic                     beat_s;

  for (genvar k = 0; k < P_REQ_NUM; k++) begin : g_slice
    assign len_arr_s[k]  = i_len[k*P_LEN_WIDTH +: P_LEN_WIDTH];
    assign data_arr_s[k] = i_wdata[k*P_DATA_WIDTH +: P_DATA_WIDTH];
  end

  rr_pick #(
    .P_REQ_NUM   (P_REQ_NUM),
    .P_IDX_WIDTH (IW)
  ) u_rr_pick (
    .req   (i_req),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s)
  );

  assign win_len_s = len_arr_s[pick_idx_s];
  assign own_req_s = i_req[owner_r];
  // A beat moves only while the owner still requests and the FIFO has room.
  assign beat_s    = (state_r == ST_BURST) && own_req_s && !i_fifo_full;

  // Next-state logic for IDLE -> GRANT -> BURST -> RELEASE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|i_req) state_s = ST_GRANT;
        else        state_s = ST_IDLE;
      end
      ST_GRANT: state_s = ST_BURST;
      ST_BURST: begin
        if (!own_req_s)                       state_s = ST_RELEASE;
        else if (beat_s && count_r == LEN_ONE) state_s = ST_RELEASE;
        else                                  state_s = ST_BURST;
      end
      ST_RELEASE: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Write-side strobes, forced to zero outside an accepted beat
  always_comb begin
    o_fifo_wr_en = beat_s;
    o_fifo_wdata = '0;
    o_ack        = '0;
    if (beat_s) begin
      o_fifo_wdata   = data_arr_s[owner_r];
      o_ack[owner_r] = 1'b1;
    end else begin
      o_fifo_wdata = '0;
      o_ack        = '0;
    end
  end

  // FSM state register and busy flag
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Grant, owner, round-robin pointer and beat counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      grant_r <= '0;
      owner_r <= '0;
      ptr_r   <= IW'(P_REQ_NUM - 1);
      count_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|i_req) begin
            grant_r <= pick_grant_s;
            owner_r <= pick_idx_s;
            count_r <= (win_len_s == '0) ? LEN_ONE : win_len_s;
          end
        end
        ST_BURST: begin
          if (beat_s) count_r <= count_r - LEN_ONE;
          if (state_s == ST_RELEASE) grant_r <= '0;
        end
        ST_RELEASE: ptr_r <= owner_r;
        default: begin
          grant_r <= grant_r;
        end
      endcase
    end
  end

  assign o_grant = grant_r;
  assign o_owner = owner_r;
  assign o_busy  = busy_r;

endmodule
